// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
//
// Handshake: the master raises mem_req together with mem_addr, mem_write and
// mem_wdata and holds all four stable until the first rising clock edge on
// which mem_ready is also high; that edge completes the transfer and mem_rdata
// is sampled on it for reads. mem_ready seen while mem_req is low means nothing.
interface multicycle_sequencer_if;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps a single-cycle datapath through
// fetch / execute / memory / writeback over one shared memory port, owns the
// instruction and load-data registers, pulses the commit enables once per
// instruction, counts retired instructions, and traps on SYSTEM or bus timeout.
module multicycle_sequencer #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          COUNT_WIDTH    = 32,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [6:0]             inst_opcode,
    input  logic                   regfile_write_request,
    input  logic [31:0]            pc,
    input  logic [31:0]            data_mem_address,
    input  logic [31:0]            data_mem_write_data,
    output logic [31:0]            inst,
    output logic [31:0]            data_mem_read_data,
    output logic                   pc_write_enable,
    output logic                   regfile_write_enable,
    multicycle_sequencer_if.master mem,
    output logic                   halted,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] instret,
    output logic [2:0]             dbg_state_o
);

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Wait counter only has to reach TIMEOUT_CYCLES-1; the extra headroom
    // keeps the width at least one bit when the timeout is disabled.
    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 2);
    localparam int             TLIM_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0]  TLIM     = TLIM_INT[TW-1:0];

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            inst_q, inst_d;
    logic [31:0]            dreg_q, dreg_d;
    logic [COUNT_WIDTH-1:0] instret_q, instret_d;
    logic [TW-1:0]          wait_q, wait_d;
    logic                   store_q, store_d;
    logic                   commit;
    logic                   timeout_now;

    // The current wait cycle is the last one allowed; a ready on it still wins.
    assign timeout_now = (TIMEOUT_CYCLES != 0) && (wait_q == TLIM);

    // State and datapath registers; reset abandons any in-flight transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            inst_q    <= NOP_INST;
            dreg_q    <= 32'd0;
            instret_q <= '0;
            wait_q    <= '0;
            store_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            dreg_q    <= dreg_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            store_q   <= store_d;
        end
    end

    // Next-state, memory request and commit decode.
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        dreg_d        = dreg_q;
        wait_d        = wait_q;
        store_d       = store_q;
        commit        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                wait_d  = '0;
                state_d = FETCH;
            end
            FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc;
                if (mem.mem_ready) begin
                    inst_d  = mem.mem_rdata;
                    state_d = EXECUTE;
                end else if (timeout_now) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            EXECUTE: begin
                wait_d = '0;
                if (inst_opcode == OP_SYSTEM) begin
                    state_d = HALT;
                end else if (inst_opcode == OP_LOAD || inst_opcode == OP_STORE) begin
                    // Latch direction so mem_write cannot glitch during MEM.
                    store_d = (inst_opcode == OP_STORE);
                    state_d = MEM;
                end else begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem.mem_req   = 1'b1;
                mem.mem_addr  = data_mem_address;
                mem.mem_write = store_q;
                mem.mem_wdata = data_mem_write_data;
                if (mem.mem_ready) begin
                    if (!store_q) begin
                        dreg_d = mem.mem_rdata;
                    end
                    state_d = WRITEBACK;
                end else if (timeout_now) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            WRITEBACK: begin
                wait_d  = '0;
                commit  = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Retired-instruction counter advances on every commit, wrapping freely.
    always_comb begin
        instret_d = instret_q;
        if (commit) begin
            instret_d = instret_q + COUNT_WIDTH'(1);
        end
    end

    assign inst                 = inst_q;
    assign data_mem_read_data   = dreg_q;
    assign pc_write_enable      = commit;
    assign regfile_write_enable = commit & regfile_write_request;
    assign halted               = (state_q == HALT);
    assign bus_error            = (state_q == ERROR);
    assign instret              = instret_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed + randomized bench for multicycle_sequencer. A small reference
// model (expected retired count, expected load register, per-phase cycle
// expectations derived from instruction class and wait counts) predicts
// every sampled output.
module tb_multicycle_sequencer;

    localparam int          CW      = 4;
    localparam int          TMO     = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_SYS  = 7'b1110011;
    localparam logic [6:0]  OP_LD   = 7'b0000011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;

    logic          clock;
    logic          reset;
    logic [6:0]    inst_opcode;
    logic          regfile_write_request;
    logic [31:0]   pc;
    logic [31:0]   data_mem_address;
    logic [31:0]   data_mem_write_data;
    logic [31:0]   inst;
    logic [31:0]   data_mem_read_data;
    logic          pc_write_enable;
    logic          regfile_write_enable;
    logic          halted;
    logic          bus_error;
    logic [CW-1:0] instret;
    logic [2:0]    dbg_state;

    multicycle_sequencer_if bus ();

    multicycle_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .COUNT_WIDTH    (CW),
        .NOP_INST       (NOP)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .inst_opcode           (inst_opcode),
        .regfile_write_request (regfile_write_request),
        .pc                    (pc),
        .data_mem_address      (data_mem_address),
        .data_mem_write_data   (data_mem_write_data),
        .inst                  (inst),
        .data_mem_read_data    (data_mem_read_data),
        .pc_write_enable       (pc_write_enable),
        .regfile_write_enable  (regfile_write_enable),
        .mem                   (bus.master),
        .halted                (halted),
        .bus_error             (bus_error),
        .instret               (instret),
        .dbg_state_o           (dbg_state)
    );

    // Decoder stand-in: opcode comes straight from the instruction register.
    assign inst_opcode = inst[6:0];

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_instret;
    logic [31:0]   exp_dreg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive memory response, check combinational outputs
    // mid-cycle, cross the edge, then check the retired count.
    task automatic cycle(input logic rdy, input logic [31:0] rd,
                         input logic e_req, input logic e_wr,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic e_pwe, input logic e_rwe);
        bus.mem_ready = rdy;
        bus.mem_rdata = rd;
        #1;
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        if (e_req) begin
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
            if (e_wr) chk("mem_wdata", bus.mem_wdata, e_wdata);
        end
        chk("pc_write_enable", 32'(pc_write_enable), 32'(e_pwe));
        chk("regfile_write_enable", 32'(regfile_write_enable), 32'(e_rwe));
        chk("halted_low", 32'(halted), 32'd0);
        chk("bus_error_low", 32'(bus_error), 32'd0);
        @(posedge clock);
        #1;
        if (e_pwe) exp_instret = exp_instret + 1'b1;
        chk("instret", 32'(instret), 32'(exp_instret));
    endtask

    // A cycle in a trap state: no request, no commit, sticky flag, count frozen.
    task automatic dead_cycle(input logic e_halt, input logic e_berr);
        bus.mem_ready = rbit();
        bus.mem_rdata = $urandom;
        #1;
        chk("trap_mem_req", 32'(bus.mem_req), 32'd0);
        chk("trap_pc_we", 32'(pc_write_enable), 32'd0);
        chk("trap_rf_we", 32'(regfile_write_enable), 32'd0);
        chk("trap_halted", 32'(halted), 32'(e_halt));
        chk("trap_bus_error", 32'(bus_error), 32'(e_berr));
        @(posedge clock);
        #1;
        chk("trap_instret", 32'(instret), 32'(exp_instret));
        chk("trap_dreg", data_mem_read_data, exp_dreg);
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge,
    // released after one edge, then the single IDLE cycle.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_dreg", data_mem_read_data, 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_pc_we", 32'(pc_write_enable), 32'd0);
        @(posedge clock);
        #1;
        reset       = 1'b0;
        exp_instret = '0;
        exp_dreg    = 32'd0;
        cycle(rbit(), $urandom, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Run one instruction from the start of FETCH. f/m = wait cycles before
    // mem_ready in FETCH / MEM (must stay below the timeout).
    task automatic run_instr(input logic [31:0] iw, input int f, input int m, input logic rq);
        logic [6:0]  op;
        logic [31:0] pcv, av, wv, rv;
        logic        st;
        op  = iw[6:0];
        pcv = $urandom & 32'hFFFF_FFFC;
        av  = $urandom;
        wv  = $urandom;
        rv  = $urandom;
        pc                    = pcv;
        data_mem_address      = av;
        data_mem_write_data   = wv;
        regfile_write_request = rq;
        for (int i = 0; i < f; i++) cycle(1'b0, $urandom, 1'b1, 1'b0, pcv, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, iw, 1'b1, 1'b0, pcv, 32'd0, 1'b0, 1'b0);
        chk("inst_reg", inst, iw);
        if (op == OP_SYS) begin
            cycle(rbit(), $urandom, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        end else if (op == OP_LD || op == OP_ST) begin
            st = (op == OP_ST);
            cycle(rbit(), $urandom, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            for (int i = 0; i < m; i++) cycle(1'b0, $urandom, 1'b1, st, av, wv, 1'b0, 1'b0);
            cycle(1'b1, rv, 1'b1, st, av, wv, 1'b0, 1'b0);
            if (!st) exp_dreg = rv;
            chk("dreg_after_mem", data_mem_read_data, exp_dreg);
            cycle(rbit(), $urandom, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rq);
            chk("dreg_after_wb", data_mem_read_data, exp_dreg);
        end else begin
            cycle(rbit(), $urandom, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rq);
            chk("dreg_after_alu", data_mem_read_data, exp_dreg);
        end
    endtask

    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                            7'b0110111, OP_LD, OP_ST};

    initial begin
        logic [31:0] r;
        logic [31:0] pcv;
        int          k;
        reset                 = 1'b0;
        regfile_write_request = 1'b0;
        pc                    = 32'd0;
        data_mem_address      = 32'd0;
        data_mem_write_data   = 32'd0;
        bus.mem_ready         = 1'b0;
        bus.mem_rdata         = 32'd0;
        exp_instret           = '0;
        exp_dreg              = 32'd0;
        @(posedge clock);
        #1;

        // Reset, then addi with zero-wait memory: commit in the second cycle.
        do_reset();
        run_instr(32'h0050_0093, 0, 0, 1'b1);
        chk("instret_after_addi", 32'(instret), 32'd1);

        // lw with three wait cycles in MEM (one short of the timeout).
        run_instr(32'h0000_a103, 0, 3, 1'b1);
        // sw without register write.
        run_instr(32'h0020_a023, 1, 2, 1'b0);
        // ALU with the longest allowed fetch wait.
        run_instr(32'h0010_8093, 3, 0, 1'b1);

        // Randomized instruction mix.
        for (int n = 0; n < 30; n++) begin
            r = $urandom;
            k = $urandom_range(0, 6);
            run_instr({r[31:7], ops[k]}, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

        // Counter wrap: 17 ALU instructions on a 4-bit counter read back 1.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            r = $urandom;
            run_instr({r[31:7], 7'b0010011}, $urandom_range(0, 3), 0, rbit());
        end
        chk("instret_wrap", 32'(instret), 32'd1);

        // Fetch timeout: four wait cycles with no ready -> ERROR.
        do_reset();
        run_instr(32'h0000_0033, 0, 0, 1'b1);
        pcv = $urandom & 32'hFFFF_FFFC;
        pc  = pcv;
        for (int i = 0; i < TMO; i++) cycle(1'b0, $urandom, 1'b1, 1'b0, pcv, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) dead_cycle(1'b0, 1'b1);
        chk("instret_after_timeout", 32'(instret), 32'd1);

        // ecall -> HALT, nothing further.
        do_reset();
        run_instr(32'h0000_0093, 0, 0, 1'b1);
        run_instr(32'h0000_0073, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) dead_cycle(1'b1, 1'b0);

        // Reset in the middle of a waiting fetch.
        do_reset();
        run_instr(32'h0030_0113, 0, 0, 1'b1);
        pcv = $urandom & 32'hFFFF_FFFC;
        pc  = pcv;
        cycle(1'b0, $urandom, 1'b1, 1'b0, pcv, 32'd0, 1'b0, 1'b0);
        do_reset();
        run_instr(32'h0040_0193, 0, 0, 1'b1);
        chk("instret_after_midreset", 32'(instret), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
